// File: rtl/ccip_resp_pkg.sv
// rtl/ccip_resp_pkg.sv - shared types and default constants for the local-memory CCI-P responder
package ccip_resp_pkg;

  localparam int DEFAULT_ADDR_WIDTH     = 10;
  localparam int DEFAULT_LINE_WIDTH     = 512;
  localparam int DEFAULT_MDATA_WIDTH    = 16;
  localparam int DEFAULT_FIFO_DEPTH     = 16;
  localparam int DEFAULT_ALM_FULL_SLACK = 4;
  localparam int LINE_ADDR_WIDTH        = 42;

  typedef logic [DEFAULT_LINE_WIDTH-1:0]  t_line;
  typedef logic [DEFAULT_MDATA_WIDTH-1:0] t_mdata;
  typedef logic [LINE_ADDR_WIDTH-1:0]     t_line_addr;
  typedef logic [DEFAULT_ADDR_WIDTH-1:0]  t_ram_addr;

  // Which channel owned the RAM port most recently; the arbiter favours the other one.
  typedef enum logic {
    LAST_RD = 1'b0,
    LAST_WR = 1'b1
  } t_grant;

  // Almost-full threshold: occupancy at which the requester must stop issuing.
  function automatic int alm_full_level(input int depth, input int slack);
    return depth - slack;
  endfunction

endpackage

// File: rtl/ccip_resp_fifo.sv
// rtl/ccip_resp_fifo.sv - show-ahead request FIFO with occupancy, full and registered almost-full
module ccip_resp_fifo
  import ccip_resp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int SLACK = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     alm_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [CW-1:0]    count_next;

  // A push into a full FIFO is dropped even if the same cycle pops; the caller flags it.
  always_comb begin
    full       = (count == CW'(DEPTH));
    push_ok    = push && !full;
    pop_ok     = pop && (count != '0);
    count_next = count + CW'(push_ok) - CW'(pop_ok);
  end

  assign head_data = mem[rd_ptr];

  // Pointer, occupancy and almost-full bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      alm_full <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      alm_full <= (count_next >= CW'(alm_full_level(DEPTH, SLACK)));
    end
  end

  // Payload storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ccip_local_mem_responder.sv
// rtl/ccip_local_mem_responder.sv - serves c0 reads and c1 writes from a local single-port line RAM
module ccip_local_mem_responder
  import ccip_resp_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int LINE_WIDTH     = DEFAULT_LINE_WIDTH,
  parameter int MDATA_WIDTH    = DEFAULT_MDATA_WIDTH,
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int ALM_FULL_SLACK = DEFAULT_ALM_FULL_SLACK
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   c0_req_valid,
  input  t_line_addr             c0_req_addr,
  input  logic [MDATA_WIDTH-1:0] c0_req_mdata,
  input  logic                   c1_req_valid,
  input  t_line_addr             c1_req_addr,
  input  logic [MDATA_WIDTH-1:0] c1_req_mdata,
  input  logic [LINE_WIDTH-1:0]  c1_req_data,
  output logic                   c0_alm_full,
  output logic                   c1_alm_full,
  output logic                   c0_rsp_valid,
  output logic [MDATA_WIDTH-1:0] c0_rsp_mdata,
  output logic [LINE_WIDTH-1:0]  c0_rsp_data,
  output logic                   c1_rsp_valid,
  output logic [MDATA_WIDTH-1:0] c1_rsp_mdata,
  output logic                   c0_not_empty,
  output logic                   c1_not_empty,
  output logic                   err_overflow
);

  localparam int RD_W = ADDR_WIDTH + MDATA_WIDTH;
  localparam int WR_W = ADDR_WIDTH + MDATA_WIDTH + LINE_WIDTH;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;

  logic [RD_W-1:0]        rd_head;
  logic [WR_W-1:0]        wr_head;
  logic [CW-1:0]          rd_count;
  logic [CW-1:0]          wr_count;
  logic                   rd_full;
  logic                   wr_full;
  logic                   rd_ne;
  logic                   wr_ne;
  logic                   grant_rd;
  logic                   grant_wr;
  t_grant                 last_grant;

  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [MDATA_WIDTH-1:0] rd_mdata;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [MDATA_WIDTH-1:0] wr_mdata;
  logic [LINE_WIDTH-1:0]  wr_data;
  logic [ADDR_WIDTH-1:0]  ram_addr;

  logic [LINE_WIDTH-1:0]  ram [2**ADDR_WIDTH];
  logic [LINE_WIDTH-1:0]  ram_q;
  logic                   rd_s1_valid;
  logic [MDATA_WIDTH-1:0] rd_s1_mdata;

  // Upper line-address bits alias onto the local RAM and are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{c0_req_addr[LINE_ADDR_WIDTH-1:ADDR_WIDTH],
                              c1_req_addr[LINE_ADDR_WIDTH-1:ADDR_WIDTH]};

  ccip_resp_fifo #(
    .WIDTH (RD_W),
    .DEPTH (FIFO_DEPTH),
    .SLACK (ALM_FULL_SLACK)
  ) u_rd_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (c0_req_valid),
    .push_data ({c0_req_addr[ADDR_WIDTH-1:0], c0_req_mdata}),
    .pop       (grant_rd),
    .head_data (rd_head),
    .count     (rd_count),
    .full      (rd_full),
    .alm_full  (c0_alm_full)
  );

  ccip_resp_fifo #(
    .WIDTH (WR_W),
    .DEPTH (FIFO_DEPTH),
    .SLACK (ALM_FULL_SLACK)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (c1_req_valid),
    .push_data ({c1_req_addr[ADDR_WIDTH-1:0], c1_req_mdata, c1_req_data}),
    .pop       (grant_wr),
    .head_data (wr_head),
    .count     (wr_count),
    .full      (wr_full),
    .alm_full  (c1_alm_full)
  );

  // Unpack FIFO heads and pick the single RAM address for this cycle.
  always_comb begin
    rd_ne    = (rd_count != '0);
    wr_ne    = (wr_count != '0);
    rd_addr  = rd_head[RD_W-1:MDATA_WIDTH];
    rd_mdata = rd_head[MDATA_WIDTH-1:0];
    wr_addr  = wr_head[WR_W-1:MDATA_WIDTH+LINE_WIDTH];
    wr_mdata = wr_head[MDATA_WIDTH+LINE_WIDTH-1:LINE_WIDTH];
    wr_data  = wr_head[LINE_WIDTH-1:0];
    ram_addr = grant_wr ? wr_addr : rd_addr;
  end

  // Alternating arbiter: when both channels wait, the one not served last wins.
  always_comb begin
    grant_rd = rd_ne && (!wr_ne || (last_grant == LAST_WR));
    grant_wr = wr_ne && !grant_rd;
  end

  // Single-port RAM, read-first; the registered output is the first read stage.
  always_ff @(posedge clk) begin
    if (grant_wr) ram[ram_addr] <= wr_data;
    ram_q <= ram[ram_addr];
  end

  // Arbiter state, read pipeline, write ack and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant   <= LAST_WR;
      rd_s1_valid  <= 1'b0;
      rd_s1_mdata  <= '0;
      c0_rsp_valid <= 1'b0;
      c0_rsp_mdata <= '0;
      c0_rsp_data  <= '0;
      c1_rsp_valid <= 1'b0;
      c1_rsp_mdata <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (grant_rd)      last_grant <= LAST_RD;
      else if (grant_wr) last_grant <= LAST_WR;

      rd_s1_valid <= grant_rd;
      if (grant_rd) rd_s1_mdata <= rd_mdata;

      c0_rsp_valid <= rd_s1_valid;
      if (rd_s1_valid) begin
        c0_rsp_mdata <= rd_s1_mdata;
        c0_rsp_data  <= ram_q;
      end

      c1_rsp_valid <= grant_wr;
      if (grant_wr) c1_rsp_mdata <= wr_mdata;

      if ((c0_req_valid && rd_full) || (c1_req_valid && wr_full)) err_overflow <= 1'b1;
    end
  end

  assign c0_not_empty = rd_ne || rd_s1_valid || c0_rsp_valid;
  assign c1_not_empty = wr_ne || c1_rsp_valid;

endmodule
